// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad scanner with column synchroniser and scan-level debounce.
// Digits 0-9 are presented on key while held (4'd10 otherwise); '*' and '#' give
// one-cycle pulses on time_button / alarm_button respectively.
// SCAN_DIV must be >= 3 so the two-flop synchroniser settles before the row sample point.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       time_button,
  output logic       alarm_button
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_SCANS);

  // Internal key codes: digits use their value, the two function keys use spare codes.
  localparam logic [3:0] NoKey    = 4'd10;
  localparam logic [3:0] StarCode = 4'd11;
  localparam logic [3:0] HashCode = 4'd12;

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed} state_e;

  // Matrix position (row*3 + col) to key code.
  function automatic logic [3:0] idx_to_code(input int idx);
    logic [3:0] code;
    case (idx)
      9:       code = StarCode;
      10:      code = 4'd0;
      11:      code = HashCode;
      default: code = 4'(idx + 1);
    endcase
    return code;
  endfunction

  logic [2:0]      col_meta_q, col_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_q, row_d;
  logic [8:0]      hit_q, hit_d;
  logic            sample, scan_done;
  logic [11:0]     keys_now;
  logic [3:0]      n_low;
  logic [3:0]      scan_code;
  logic            single, none;

  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CntW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic [3:0]      key_q, key_d;
  logic            time_q, time_d;
  logic            alarm_q, alarm_d;
  logic            accept;

  // Two-flop synchroniser; idles high so reset looks like "no key".
  always_ff @(posedge clock) begin
    if (reset) begin
      col_meta_q <= 3'b111;
      col_sync_q <= 3'b111;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  assign sample    = (div_q == DivLast);
  assign scan_done = sample && (row_q == 2'd3);

  // Row slot timing: divider runs 0..SCAN_DIV-1, then the row advances (wrapping 3 -> 0).
  always_comb begin
    div_d = div_q + DivW'(1);
    row_d = row_q;
    if (sample) begin
      div_d = '0;
      row_d = row_q + 2'd1;
    end
  end

  // Capture rows 0..2 at their sample points; row 3 is taken live at scan end.
  always_comb begin
    hit_d = hit_q;
    if (sample) begin
      case (row_q)
        2'd0:    hit_d[2:0] = ~col_sync_q;
        2'd1:    hit_d[5:3] = ~col_sync_q;
        2'd2:    hit_d[8:6] = ~col_sync_q;
        default: ;
      endcase
    end
  end

  // Scan counters and captured hits.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      row_q <= '0;
      hit_q <= '0;
    end else begin
      div_q <= div_d;
      row_q <= row_d;
      hit_q <= hit_d;
    end
  end

  assign row_n    = ~(4'b0001 << row_q);
  assign keys_now = {~col_sync_q, hit_q};

  // Classify the full scan: number of keys down and the code of the (last) one found.
  always_comb begin
    n_low     = '0;
    scan_code = NoKey;
    for (int i = 0; i < 12; i++) begin
      if (keys_now[i]) begin
        n_low     = n_low + 4'd1;
        scan_code = idx_to_code(i);
      end
    end
  end

  assign single   = (n_low == 4'd1);
  assign none     = (n_low == 4'd0);
  assign cnt_inc  = cnt_q + CntW'(1);
  assign rcnt_inc = rcnt_q + CntW'(1);

  // Debounce FSM next state and outputs; evaluated once per completed scan.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    key_d   = key_q;
    time_d  = 1'b0;
    alarm_d = 1'b0;
    accept  = 1'b0;
    if (scan_done) begin
      unique case (state_q)
        StIdle: begin
          if (single) begin
            cand_d = scan_code;
            cnt_d  = CntW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept = 1'b1;
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (single && (scan_code == cand_q)) begin
            if (cnt_inc == CntLast) begin
              accept = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StPressed: begin
          if (none) begin
            if (rcnt_inc == CntLast) begin
              key_d   = NoKey;
              rcnt_d  = '0;
              state_d = StIdle;
            end else begin
              rcnt_d = rcnt_inc;
            end
          end else begin
            // Any activity while pressed restarts the release count; no re-fire.
            rcnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (accept) begin
      state_d = StPressed;
      cnt_d   = '0;
      rcnt_d  = '0;
      if (cand_d == StarCode) begin
        time_d = 1'b1;
      end else if (cand_d == HashCode) begin
        alarm_d = 1'b1;
      end else begin
        key_d = cand_d;
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cand_q  <= NoKey;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      key_q   <= NoKey;
      time_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      key_q   <= key_d;
      time_q  <= time_d;
      alarm_q <= alarm_d;
    end
  end

  assign key          = key_q;
  assign time_button  = time_q;
  assign alarm_button = alarm_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Cycle c after a reset is the cycle in which div=c%4 and row=(c/4)%4; outputs are
// sampled on the falling edge, so cycle c shows state written by the c-th rising edge.
module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key;
  logic        time_button;
  logic        alarm_button;
  logic [11:0] pressed = '0;  // bit r*3+c = key at (row r, col c) held down

  int compared   = 0;
  int mismatched = 0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .col_n       (col_n),
    .row_n       (row_n),
    .key         (key),
    .time_button (time_button),
    .alarm_button(alarm_button)
  );

  always #5 clock = ~clock;

  // Keypad model: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 3'b111;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  // Leaves the bench at the falling edge of cycle 0 after reset.
  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] want_row;
    pressed = '0;
    do_reset(5);
    compared++;
    if (key !== 4'd10) begin
      mismatched++;
      $display("FAIL reset_key: got %0d, want 10", key);
    end
    compared++;
    if (time_button !== 1'b0 || alarm_button !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_pulses: got time=%b alarm=%b, want 0 0", time_button, alarm_button);
    end
    for (int c = 0; c <= 16; c++) begin
      if (c == 0 || c == 3 || c == 4 || c == 8 || c == 12 || c == 16) begin
        case ((c / 4) % 4)
          0:       want_row = 4'b1110;
          1:       want_row = 4'b1101;
          2:       want_row = 4'b1011;
          default: want_row = 4'b0111;
        endcase
        compared++;
        if (row_n !== want_row) begin
          mismatched++;
          $display("FAIL row_n_cycle%0d: got %b, want %b", c, row_n, want_row);
        end
      end
      @(negedge clock);
    end
  endtask

  // Hold '5' for 20 scans: accepted at edge 48, released at cycle 320 -> clears at edge 368.
  task automatic test_digit_hold();
    int bad;
    bad = 0;
    pressed = '0;
    do_reset(1);
    pressed[4] = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (c == 320) pressed[4] = 1'b0;
      if (c == 47) begin
        compared++;
        if (key !== 4'd10) begin
          mismatched++;
          $display("FAIL key5_before_accept: got %0d, want 10", key);
        end
      end
      if (c == 48) begin
        compared++;
        if (key !== 4'd5) begin
          mismatched++;
          $display("FAIL key5_accept: got %0d, want 5", key);
        end
      end
      if (c == 367) begin
        compared++;
        if (key !== 4'd5) begin
          mismatched++;
          $display("FAIL key5_before_release: got %0d, want 5", key);
        end
      end
      if (c == 368) begin
        compared++;
        if (key !== 4'd10) begin
          mismatched++;
          $display("FAIL key5_release: got %0d, want 10", key);
        end
      end
      if (c > 48 && c < 367 && key !== 4'd5) bad++;
      if (time_button !== 1'b0 || alarm_button !== 1'b0) bad++;
      @(negedge clock);
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL key5_hold_stable: got %0d bad cycles, want 0", bad);
    end
  endtask

  // '*' then '#': one pulse each at cycle 48, key stays 10, other pulse never fires.
  task automatic test_func_keys();
    for (int k = 0; k < 2; k++) begin
      int   pulses;
      int   other;
      int   keybad;
      logic p;
      logic o;
      pulses = 0;
      other  = 0;
      keybad = 0;
      pressed = '0;
      do_reset(1);
      pressed[(k == 0) ? 9 : 11] = 1'b1;
      for (int c = 0; c < 220; c++) begin
        if (c == 160) pressed = '0;
        p = (k == 0) ? time_button : alarm_button;
        o = (k == 0) ? alarm_button : time_button;
        if (c == 47 || c == 49) begin
          compared++;
          if (p !== 1'b0) begin
            mismatched++;
            $display("FAIL func%0d_no_pulse_cycle%0d: got %b, want 0", k, c, p);
          end
        end
        if (c == 48) begin
          compared++;
          if (p !== 1'b1) begin
            mismatched++;
            $display("FAIL func%0d_pulse_cycle48: got %b, want 1", k, p);
          end
        end
        if (p === 1'b1) pulses++;
        if (o !== 1'b0) other++;
        if (key !== 4'd10) keybad++;
        @(negedge clock);
      end
      compared++;
      if (pulses != 1) begin
        mismatched++;
        $display("FAIL func%0d_pulse_count: got %0d, want 1", k, pulses);
      end
      compared++;
      if (other != 0) begin
        mismatched++;
        $display("FAIL func%0d_other_pulse: got %0d cycles, want 0", k, other);
      end
      compared++;
      if (keybad != 0) begin
        mismatched++;
        $display("FAIL func%0d_key_stays_10: got %0d bad cycles, want 0", k, keybad);
      end
    end
  endtask

  // Toggle '1' every 10 cycles from cycle 2; row-0 samples never see 3 in a row.
  // Steady from cycle 202 -> scans 13,14,15 match -> key=1 at edge 256.
  task automatic test_bounce();
    int bad;
    bad = 0;
    pressed = '0;
    do_reset(1);
    for (int c = 0; c < 260; c++) begin
      if (c >= 2 && c <= 192 && (c - 2) % 10 == 0) pressed[0] = ~pressed[0];
      if (c == 202) pressed[0] = 1'b1;
      if (c < 255) begin
        if (key !== 4'd10 || time_button !== 1'b0 || alarm_button !== 1'b0) bad++;
      end
      if (c == 256) begin
        compared++;
        if (key !== 4'd1) begin
          mismatched++;
          $display("FAIL bounce_then_steady: got %0d, want 1", key);
        end
      end
      @(negedge clock);
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL bounce_rejected: got %0d bad cycles, want 0", bad);
    end
    pressed = '0;
  endtask

  // 1+2 together never accepted; then 1 alone (accept at 288), add 2, drop 1, release all.
  task automatic test_multi();
    int bad_multi;
    int bad_hold;
    bad_multi = 0;
    bad_hold  = 0;
    pressed = '0;
    do_reset(1);
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    for (int c = 0; c < 540; c++) begin
      if (c == 160) pressed = '0;
      if (c == 240) pressed[0] = 1'b1;
      if (c == 320) pressed[1] = 1'b1;
      if (c == 400) pressed[0] = 1'b0;
      if (c == 480) pressed = '0;
      if (c < 240 && key !== 4'd10) bad_multi++;
      if (c == 288) begin
        compared++;
        if (key !== 4'd1) begin
          mismatched++;
          $display("FAIL multi_single_accept: got %0d, want 1", key);
        end
      end
      if (c > 288 && c <= 527 && key !== 4'd1) bad_hold++;
      if (c == 528) begin
        compared++;
        if (key !== 4'd10) begin
          mismatched++;
          $display("FAIL multi_final_release: got %0d, want 10", key);
        end
      end
      @(negedge clock);
    end
    compared++;
    if (bad_multi != 0) begin
      mismatched++;
      $display("FAIL multi_two_keys_rejected: got %0d bad cycles, want 0", bad_multi);
    end
    compared++;
    if (bad_hold != 0) begin
      mismatched++;
      $display("FAIL multi_key1_held_through: got %0d bad cycles, want 0", bad_hold);
    end
  endtask

  // '7' accepted, 1-cycle reset while held, then a fresh 3-scan debounce.
  task automatic test_reset_mid();
    pressed = '0;
    do_reset(1);
    pressed[6] = 1'b1;
    repeat (48) @(negedge clock);
    compared++;
    if (key !== 4'd7) begin
      mismatched++;
      $display("FAIL key7_accept: got %0d, want 7", key);
    end
    do_reset(1);
    compared++;
    if (key !== 4'd10) begin
      mismatched++;
      $display("FAIL key7_reset_clears: got %0d, want 10", key);
    end
    compared++;
    if (row_n !== 4'b1110) begin
      mismatched++;
      $display("FAIL key7_reset_row: got %b, want 1110", row_n);
    end
    repeat (47) @(negedge clock);
    compared++;
    if (key !== 4'd10) begin
      mismatched++;
      $display("FAIL key7_redebounce_early: got %0d, want 10", key);
    end
    @(negedge clock);
    compared++;
    if (key !== 4'd7) begin
      mismatched++;
      $display("FAIL key7_redebounce: got %0d, want 7", key);
    end
    pressed = '0;
  endtask

  initial begin
    test_reset();
    test_digit_hold();
    test_func_keys();
    test_bounce();
    test_multi();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
